ball_motion: RTL and testbench



---
 rtl/ball_motion.sv | 166 ++++++++++++++++
 tb/tb_ball_motion.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ball_motion.sv
// Frame-rate basketball trajectory engine: latches launch velocities on a shot,
// integrates position under constant gravity once per frame, scores made/miss,
// holds the final position and then re-racks the ball at the start point.
module ball_motion #(
  parameter int START_X     = 80,
  parameter int START_Y     = 400,
  parameter int HOOP_XL     = 520,
  parameter int HOOP_XR     = 560,
  parameter int HOOP_Y      = 200,
  parameter int FLOOR_Y     = 440,
  parameter int X_MAX       = 624,
  parameter int GRAVITY     = 4,
  parameter int HOLD_FRAMES = 60
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       frame_tick,
  input  logic       shoot,
  input  logic [7:0] vx_in,
  input  logic [7:0] vy_in,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic       in_flight,
  output logic       shot_done,
  output logic       made
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] FLIGHT = 2'd1;
  localparam logic [1:0] HOLD   = 2'd2;

  localparam int HOLD_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_FRAMES - 1);

  localparam logic        [13:0] START_PX = 14'(START_X * 16);
  localparam logic signed [15:0] START_PY = 16'(START_Y * 16);
  localparam logic        [13:0] X_LIM_PX = 14'(X_MAX * 16);
  localparam logic signed [15:0] Y_LIM_PY = 16'(FLOOR_Y * 16);

  localparam logic        [10:0] HOOP_XL11 = 11'(HOOP_XL);
  localparam logic        [10:0] HOOP_XR11 = 11'(HOOP_XR);
  localparam logic        [10:0] X_MAX11   = 11'(X_MAX);
  localparam logic signed [11:0] HOOP_Y12  = 12'(HOOP_Y);
  localparam logic signed [12:0] HOOP_Y13  = 13'(HOOP_Y);
  localparam logic signed [12:0] FLOOR13   = 13'(FLOOR_Y);
  localparam logic signed [12:0] GRAV13    = 13'(GRAVITY);
  localparam logic signed [12:0] VY_CAP13  = 13'sd2047;
  localparam logic signed [11:0] VY_CAP12  = 12'sd2047;

  logic        [1:0]        state;
  logic        [13:0]       pos_x;
  logic signed [15:0]       pos_y;
  logic        [7:0]        vx;
  logic signed [11:0]       vy;
  logic        [HOLD_W-1:0] hold_cnt;

  // One candidate motion step, computed every cycle and committed only on a flight tick
  logic        [14:0] sum_x;
  logic signed [16:0] sum_y;
  logic        [10:0] new_x_int;
  logic signed [12:0] new_y_int;
  logic signed [11:0] old_y_int;
  logic signed [12:0] vy_inc;
  logic        [13:0] pos_x_next;
  logic signed [15:0] pos_y_next;
  logic signed [11:0] vy_next;
  logic               hit;
  logic               miss;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    sum_x      = {1'b0, pos_x} + {7'd0, vx};
    sum_y      = {pos_y[15], pos_y} + {{5{vy[11]}}, vy};
    new_x_int  = sum_x[14:4];
    new_y_int  = sum_y[16:4];
    old_y_int  = pos_y[15:4];
    vy_inc     = {vy[11], vy} + GRAV13;
    vy_next    = vy_inc[11:0];
    pos_x_next = sum_x[13:0];
    pos_y_next = sum_y[15:0];

    if (vy_inc > VY_CAP13) begin
      vy_next = VY_CAP12;
    end

    // Made needs a downward crossing of the rim line inside the scoring window
    hit = (vy > 12'sd0) && (old_y_int < HOOP_Y12) && (new_y_int >= HOOP_Y13) &&
          (new_x_int >= HOOP_XL11) && (new_x_int <= HOOP_XR11);
    miss = (new_y_int >= FLOOR13) || (new_x_int > X_MAX11);

    // The ball never leaves the floor or the right edge, even when the shot scores
    if (new_y_int >= FLOOR13) begin
      pos_y_next = Y_LIM_PY;
    end
    if (new_x_int > X_MAX11) begin
      pos_x_next = X_LIM_PX;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      pos_x     <= START_PX;
      pos_y     <= START_PY;
      vx        <= '0;
      vy        <= '0;
      hold_cnt  <= '0;
      shot_done <= 1'b0;
      made      <= 1'b0;
    end else begin
      shot_done <= 1'b0;
      case (state)
        IDLE: begin
          if (shoot) begin
            vx    <= vx_in;
            vy    <= 12'sd0 - $signed({4'd0, vy_in});
            made  <= 1'b0;
            state <= FLIGHT;
          end
        end
        FLIGHT: begin
          if (frame_tick) begin
            pos_x <= pos_x_next;
            pos_y <= pos_y_next;
            vy    <= vy_next;
            if (hit || miss) begin
              made      <= hit;
              shot_done <= 1'b1;
              hold_cnt  <= '0;
              state     <= HOLD;
            end
          end
        end
        HOLD: begin
          if (frame_tick) begin
            if (hold_cnt == HOLD_LAST) begin
              pos_x <= START_PX;
              pos_y <= START_PY;
              vx    <= '0;
              vy    <= '0;
              state <= IDLE;
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Display coordinates trail the position registers by one cycle; above-screen reads as row 0
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ball_x <= 10'(START_X);
      ball_y <= 10'(START_Y);
    end else begin
      ball_x <= pos_x[13:4];
      ball_y <= pos_y[15] ? 10'd0 : pos_y[13:4];
    end
  end

  assign in_flight = (state == FLIGHT);

endmodule

// File: tb/tb_ball_motion.sv
// Bench for ball_motion: two instances (default hoop and a hoop at the start column)
// are compared every cycle against an integer-arithmetic model of the ball's flight.
module tb_ball_motion;

  localparam int START_X     = 80;
  localparam int START_Y     = 400;
  localparam int FLOOR_Y     = 440;
  localparam int X_MAX       = 624;
  localparam int GRAVITY     = 4;
  localparam int HOLD_FRAMES = 60;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       frame_tick = 1'b0;
  logic       shoot = 1'b0;
  logic [7:0] vx_in = '0;
  logic [7:0] vy_in = '0;

  logic [9:0] a_ball_x, a_ball_y, b_ball_x, b_ball_y;
  logic       a_in_flight, a_shot_done, a_made;
  logic       b_in_flight, b_shot_done, b_made;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ball_motion dut_a (
    .clk        (clk),
    .reset_n    (reset_n),
    .frame_tick (frame_tick),
    .shoot      (shoot),
    .vx_in      (vx_in),
    .vy_in      (vy_in),
    .ball_x     (a_ball_x),
    .ball_y     (a_ball_y),
    .in_flight  (a_in_flight),
    .shot_done  (a_shot_done),
    .made       (a_made)
  );

  ball_motion #(.HOOP_XL(70), .HOOP_XR(90), .HOOP_Y(300)) dut_b (
    .clk        (clk),
    .reset_n    (reset_n),
    .frame_tick (frame_tick),
    .shoot      (shoot),
    .vx_in      (vx_in),
    .vy_in      (vy_in),
    .ball_x     (b_ball_x),
    .ball_y     (b_ball_y),
    .in_flight  (b_in_flight),
    .shot_done  (b_shot_done),
    .made       (b_made)
  );

  // Reference ball: positions in 1/16 px as plain integers
  typedef struct {
    int px, py, vx, vy, held, bx, by;
    bit flying, holding, made, done;
  } ball_t;

  ball_t m[2];
  int p_xl[2] = '{520, 70};
  int p_xr[2] = '{560, 90};
  int p_hy[2] = '{200, 300};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m[i].px = START_X * 16;
      m[i].py = START_Y * 16;
      m[i].vx = 0;
      m[i].vy = 0;
      m[i].held = 0;
      m[i].bx = START_X;
      m[i].by = START_Y;
      m[i].flying = 1'b0;
      m[i].holding = 1'b0;
      m[i].made = 1'b0;
      m[i].done = 1'b0;
    end
  endtask

  task automatic model_step(input bit tick, input bit sh, input int vxi, input int vyi);
    for (int i = 0; i < 2; i++) begin
      int nx, ny, xi, yi, oyi;
      bit scored, out;
      m[i].done = 1'b0;
      m[i].bx = m[i].px >>> 4;
      m[i].by = (m[i].py < 0) ? 0 : (m[i].py >>> 4);
      if (!m[i].flying && !m[i].holding) begin
        if (sh) begin
          m[i].vx = vxi;
          m[i].vy = -vyi;
          m[i].made = 1'b0;
          m[i].flying = 1'b1;
        end
      end else if (m[i].flying) begin
        if (tick) begin
          nx = m[i].px + m[i].vx;
          ny = m[i].py + m[i].vy;
          xi = nx / 16;
          yi = ny >>> 4;
          oyi = m[i].py >>> 4;
          scored = (m[i].vy > 0) && (oyi < p_hy[i]) && (yi >= p_hy[i]) &&
                   (xi >= p_xl[i]) && (xi <= p_xr[i]);
          out = (yi >= FLOOR_Y) || (xi > X_MAX);
          if (yi >= FLOOR_Y) ny = FLOOR_Y * 16;
          if (xi > X_MAX) nx = X_MAX * 16;
          m[i].px = nx;
          m[i].py = ny;
          m[i].vy = (m[i].vy + GRAVITY > 2047) ? 2047 : m[i].vy + GRAVITY;
          if (scored || out) begin
            m[i].flying = 1'b0;
            m[i].holding = 1'b1;
            m[i].held = 0;
            m[i].made = scored;
            m[i].done = 1'b1;
          end
        end
      end else if (tick) begin
        m[i].held++;
        if (m[i].held == HOLD_FRAMES) begin
          m[i].holding = 1'b0;
          m[i].px = START_X * 16;
          m[i].py = START_Y * 16;
          m[i].vx = 0;
          m[i].vy = 0;
        end
      end
    end
  endtask

  task automatic compare_all();
    check("a_ball_x", a_ball_x, m[0].bx);
    check("a_ball_y", a_ball_y, m[0].by);
    check("a_in_flight", a_in_flight, m[0].flying);
    check("a_shot_done", a_shot_done, m[0].done);
    check("a_made", a_made, m[0].made);
    check("b_ball_x", b_ball_x, m[1].bx);
    check("b_ball_y", b_ball_y, m[1].by);
    check("b_in_flight", b_in_flight, m[1].flying);
    check("b_shot_done", b_shot_done, m[1].done);
    check("b_made", b_made, m[1].made);
  endtask

  // One clock cycle, entered and left on a falling edge
  task automatic cycle(input bit tick, input bit sh, input logic [7:0] vx, input logic [7:0] vy);
    frame_tick = tick;
    shoot = sh;
    vx_in = vx;
    vy_in = vy;
    @(posedge clk);
    model_step(tick, sh, int'(vx), int'(vy));
    #1 compare_all();
    @(negedge clk);
    frame_tick = 1'b0;
    shoot = 1'b0;
  endtask

  task automatic frame();
    repeat (3) cycle(1'b0, 1'b0, 8'd0, 8'd0);
    cycle(1'b1, 1'b0, 8'd0, 8'd0);
  endtask

  task automatic fly(input int max_frames, output int nf);
    nf = 0;
    while ((a_in_flight || b_in_flight) && nf < max_frames) begin
      frame();
      nf++;
    end
    check("flight_ended", a_in_flight | b_in_flight, 1'b0);
  endtask

  task automatic async_reset();
    #2 reset_n = 1'b0;
    #1 model_reset();
    check("rst_ball_x", a_ball_x, 80);
    check("rst_ball_y", a_ball_y, 400);
    check("rst_in_flight", a_in_flight, 1'b0);
    check("rst_shot_done", a_shot_done, 1'b0);
    check("rst_made", a_made, 1'b0);
    compare_all();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int nf;

    // Reset with no clock edge in between
    async_reset();

    // Floor miss, with shoot pulses ignored during flight and hold
    cycle(1'b0, 1'b1, 8'd32, 8'd0);
    check("launch_in_flight", a_in_flight, 1'b1);
    nf = 0;
    while (a_in_flight && nf < 200) begin
      frame();
      nf++;
      if (nf == 5) cycle(1'b0, 1'b1, 8'd200, 8'd200);
    end
    check("floor_tick_count", nf, 19);
    check("floor_shot_done", a_shot_done, 1'b1);
    cycle(1'b0, 1'b0, 8'd0, 8'd0);
    check("floor_x", a_ball_x, 118);
    check("floor_y_clamped", a_ball_y, 440);
    check("floor_made", a_made, 1'b0);
    check("floor_pulse_width", a_shot_done, 1'b0);
    for (int k = 0; k < 59; k++) begin
      frame();
      if (k == 10) cycle(1'b0, 1'b1, 8'd50, 8'd50);
    end
    cycle(1'b0, 1'b0, 8'd0, 8'd0);
    check("hold_frozen_y", a_ball_y, 440);
    frame();
    cycle(1'b0, 1'b0, 8'd0, 8'd0);
    check("rerack_x", a_ball_x, 80);
    check("rerack_y", a_ball_y, 400);
    check("rerack_idle", a_in_flight, 1'b0);

    // Shoot coincident with a frame tick: no motion until the following tick
    cycle(1'b1, 1'b1, 8'd64, 8'd64);
    cycle(1'b0, 1'b0, 8'd0, 8'd0);
    check("coinc_x", a_ball_x, 80);
    check("coinc_y", a_ball_y, 400);
    frame();
    cycle(1'b0, 1'b0, 8'd0, 8'd0);
    check("first_step_x", a_ball_x, 84);
    check("first_step_y", a_ball_y, 396);
    repeat (3) frame();
    async_reset();

    // Basket on the column hoop instance; default instance lands on the floor
    cycle(1'b0, 1'b1, 8'd0, 8'd160);
    fly(300, nf);
    cycle(1'b0, 1'b0, 8'd0, 8'd0);
    check("basket_made", b_made, 1'b1);
    check("basket_x", b_ball_x, 80);
    check("basket_y", b_ball_y, 303);
    check("no_hoop_made", a_made, 1'b0);
    check("no_hoop_y", a_ball_y, 440);
    repeat (HOLD_FRAMES + 1) frame();

    // Ball leaves the top of the screen without being a miss
    cycle(1'b0, 1'b1, 8'd0, 8'd255);
    repeat (60) frame();
    cycle(1'b0, 1'b0, 8'd0, 8'd0);
    check("top_clamp_y", a_ball_y, 0);
    check("top_still_flying", a_in_flight, 1'b1);
    fly(400, nf);
    check("top_miss_made", a_made, 1'b0);
    check("top_basket_made", b_made, 1'b1);
    repeat (HOLD_FRAMES + 1) frame();

    // Random ticks, shots and velocities
    for (int k = 0; k < 3000; k++) begin
      if (k == 1700) async_reset();
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0,
            8'($urandom), 8'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
